// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: reset PC default,
// the queue entry layout and the pointer width helper.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One buffered fetch: its address, the returned word and whether the
  // word has arrived yet.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        filled;
  } ifq_entry_t;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch queue bus: instruction memory request/response on one side,
// Decode hand-off and redirect on the other.
// master = the fetch queue, slave = memory plus Decode.
interface inst_fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/inst_fetch_queue_storage.sv
// Entry array of the fetch queue. Allocation writes the pc and clears the
// filled flag, fill writes the data and sets it; the head is read
// combinationally so Decode sees it in the same cycle.
module ifq_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_en_i,
  input  logic [IW-1:0] alloc_idx_i,
  input  logic [31:0]   alloc_pc_i,
  input  logic          fill_en_i,
  input  logic [IW-1:0] fill_idx_i,
  input  logic [31:0]   fill_data_i,
  input  logic [IW-1:0] rd_idx_i,
  output ifq_entry_t    rd_entry_o
);

  ifq_entry_t entry_vec [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    ifq_entry_t entry_q;
    logic       alloc_hit;
    logic       fill_hit;

    assign alloc_hit = alloc_en_i && (alloc_idx_i == IW'(gi));
    assign fill_hit  = fill_en_i  && (fill_idx_i  == IW'(gi));

    // Allocation and fill never target the same slot in one cycle, so the
    // two field updates are independent.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        entry_q <= '0;
      end else begin
        if (alloc_hit) begin
          entry_q.pc     <= alloc_pc_i;
          entry_q.filled <= 1'b0;
        end
        if (fill_hit) begin
          entry_q.data   <= fill_data_i;
          entry_q.filled <= 1'b1;
        end
      end
    end

    assign entry_vec[gi] = entry_q;
  end

  assign rd_entry_o = entry_vec[rd_idx_i];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues in-order requests to a
// variable-latency instruction memory within a credit window of DEPTH,
// buffers responses in order and hands one instruction per cycle to
// Decode. A redirect empties the queue and counts the in-flight responses
// that must be thrown away when they arrive.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  inst_fetch_queue_if.master bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int IW = PW - 1;
  localparam logic [PW:0] DEPTH_W = DEPTH[PW:0];

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] drop_q, drop_d;

  logic          grant;
  logic          pop;
  logic          fill_en;
  logic          drop_rsp;
  logic [PW:0]   used;
  ifq_entry_t    head_entry;

  // Credit covers both live entries and responses still owed to a flush.
  assign used = {1'b0, alloc_q - head_q} + {1'b0, drop_q};

  // No request while in reset or while Decode is redirecting.
  assign bus.imem_req  = rst && (used < DEPTH_W) && !bus.redirect;
  assign bus.imem_addr = fetch_pc_q;

  assign grant    = bus.imem_req && bus.imem_gnt;
  assign drop_rsp = bus.imem_rvalid && (drop_q != '0);
  assign fill_en  = bus.imem_rvalid && (drop_q == '0) && !bus.redirect;

  // The filled flag is redundant with the pointer test but keeps a
  // not-yet-returned slot from ever looking valid.
  assign bus.instr_valid    = (head_q != fill_q) && head_entry.filled;
  assign pop                = bus.instr_valid && bus.instr_ready && !bus.redirect;
  assign bus.instr          = head_entry.data;
  assign bus.instr_pc       = head_entry.pc;
  assign bus.instr_pc_plus4 = head_entry.pc + 32'd4;

  ifq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk         (clk),
    .rst         (rst),
    .alloc_en_i  (grant),
    .alloc_idx_i (alloc_q[IW-1:0]),
    .alloc_pc_i  (fetch_pc_q),
    .fill_en_i   (fill_en),
    .fill_idx_i  (fill_q[IW-1:0]),
    .fill_data_i (bus.imem_rdata),
    .rd_idx_i    (head_q[IW-1:0]),
    .rd_entry_o  (head_entry)
  );

  // Next-state for PC, pointers and drop counter; redirect overrides all.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    head_d     = head_q;
    drop_d     = drop_q;
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc & ~32'h3;
      fill_d     = alloc_q;
      head_d     = alloc_q;
      // Everything allocated but not yet filled is still in flight; a
      // response arriving this cycle is already consumed.
      drop_d     = drop_q + (alloc_q - fill_q) - PW'(bus.imem_rvalid);
    end else begin
      if (grant) begin
        alloc_d    = alloc_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (drop_rsp) begin
        drop_d = drop_q - PW'(1);
      end else if (fill_en) begin
        fill_d = fill_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      alloc_q    <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      head_q     <= head_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: in-order memory model with programmable
// latency, grant-time scoreboard of expected instructions, a table of
// redirect scenarios and a few hand-written corner sequences.
`timescale 1ns/1ps
module tb_inst_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_queue_if bus();

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // ---------------- memory model ----------------
  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;

  int    cyc = 0;
  int    mem_lat = 1;
  mreq_t mq[$];

  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst) begin
        mq.delete();
        bus.imem_rvalid = 1'b0;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = word_of(mq[0].addr);
        mq.delete(0);
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] exp_q[$];
  int          grant_cnt = 0;
  int          pop_cnt = 0;
  int          first_valid_cyc = -1;
  int          first_grant_cyc = -1;
  logic [31:0] last_grant_addr = '0;
  logic [31:0] last_pop_pc = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (bus.instr_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("stale_valid", 32'd1, 32'd0);
        end else begin
          check("head_pc", bus.instr_pc, exp_q[0]);
          check("head_instr", bus.instr, word_of(exp_q[0]));
          check("head_pc_plus4", bus.instr_pc_plus4, exp_q[0] + 32'd4);
          if (bus.instr_ready && !bus.redirect) begin
            last_pop_pc = exp_q[0];
            $display("pop   cyc=%0d pc=%h instr=%h", cyc, bus.instr_pc, bus.instr);
            exp_q.delete(0);
            pop_cnt++;
          end
        end
      end
      if (prev_stall && bus.imem_req) check("addr_stable", bus.imem_addr, prev_addr);
      if (bus.redirect) exp_q.delete();
      if (bus.imem_req && bus.imem_gnt) begin
        exp_q.push_back(bus.imem_addr);
        mq.push_back('{cyc + mem_lat, bus.imem_addr});
        grant_cnt++;
        last_grant_addr = bus.imem_addr;
        if (first_grant_cyc < 0) first_grant_cyc = cyc;
      end
      prev_stall = bus.imem_req && !bus.imem_gnt;
      prev_addr  = bus.imem_addr;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic clear_counters();
    grant_cnt = 0; pop_cnt = 0;
    first_valid_cyc = -1; first_grant_cyc = -1;
  endtask

  task automatic do_reset(input int lat, input logic gnt, input logic rdy);
    @(posedge clk); #3;
    rst = 1'b0;
    bus.redirect = 1'b0;
    bus.imem_gnt = gnt;
    bus.instr_ready = rdy;
    mem_lat = lat;
    repeat (2) step();
    rst = 1'b1;
    clear_counters();
  endtask

  task automatic wait_grants(input int n, input string name);
    int k = 0;
    while (grant_cnt < n && k < 60) begin step(); k++; end
    if (grant_cnt < n) check({name, "_grant_timeout"}, grant_cnt, n);
  endtask

  task automatic wait_pops(input int n, input string name);
    int k = 0;
    while (pop_cnt < n && k < 60) begin step(); k++; end
    if (pop_cnt < n) check({name, "_pop_timeout"}, pop_cnt, n);
  endtask

  // ---------------- redirect vector table ----------------
  typedef struct {
    int          lat;
    int          n_grants;
    logic [31:0] pc1;
    bit          twice;
    logic [31:0] pc2;
    logic [31:0] exp_pc;
  } rd_vec_t;

  rd_vec_t vecs[6];

  initial begin
    int p0;
    int rcyc;

    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int rcyc;

    vecs[0] = '{3, 3, 32'h0000_0100, 1'b0, 32'h0,         32'h0000_0100};
    vecs[1] = '{2, 2, 32'h0000_0203, 1'b0, 32'h0,         32'h0000_0200};
    vecs[2] = '{1, 5, 32'hFFFF_FFFE, 1'b0, 32'h0,         32'hFFFF_FFFC};
    vecs[3] = '{4, 1, 32'h0000_0040, 1'b0, 32'h0,         32'h0000_0040};
    vecs[4] = '{3, 2, 32'h0000_1000, 1'b1, 32'h0000_2001, 32'h0000_2000};
    vecs[5] = '{1, 3, 32'h0000_0080, 1'b1, 32'h0000_0084, 32'h0000_0084};

    bus.imem_gnt    = 1'b1;
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    mem_lat         = 1;

    // Reset state, then straight-line fetch at L=1.
    #12;
    check("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_instr_pc", bus.instr_pc, 32'd0);
    check("rst_pc_plus4", bus.instr_pc_plus4, 32'd4);
    step(); step();
    rst = 1'b1;
    clear_counters();
    wait_grants(1, "stream");
    check("stream_first_addr", last_grant_addr, 32'd0);
    wait_pops(1, "stream");
    check("stream_first_pc", last_pop_pc, 32'd0);
    check("stream_latency", first_valid_cyc - first_grant_cyc, 32'd2);
    p0 = pop_cnt;
    repeat (8) step();
    check("stream_throughput", pop_cnt - p0, 32'd8);

    // Decode stalled: the credit window fills and fetch stops at 16.
    do_reset(1, 1'b1, 1'b0);
    repeat (10) step();
    check("full_grants", grant_cnt, 32'd4);
    check("full_req_low", {31'd0, bus.imem_req}, 32'd0);
    check("full_addr", bus.imem_addr, 32'd16);
    bus.instr_ready = 1'b1;
    wait_grants(5, "full");
    check("full_resume_addr", last_grant_addr, 32'd16);
    wait_pops(4, "full");
    check("full_fourth_pop", last_pop_pc, 32'd12);

    // Table of redirects with responses in flight.
    foreach (vecs[i]) begin
      do_reset(vecs[i].lat, 1'b1, 1'b1);
      wait_grants(vecs[i].n_grants, "redir");
      bus.redirect = 1'b1;
      bus.redirect_pc = vecs[i].pc1;
      rcyc = cyc;
      step();
      if (vecs[i].twice) begin
        bus.redirect_pc = vecs[i].pc2;
        rcyc = cyc;
        step();
      end
      bus.redirect = 1'b0;
      first_valid_cyc = -1;
      p0 = pop_cnt;
      $display("redir vec=%0d lat=%0d target=%h", i, vecs[i].lat, vecs[i].exp_pc);
      wait_pops(p0 + 1, "redir");
      check("redir_first_pc", last_pop_pc, vecs[i].exp_pc);
      check("redir_latency", first_valid_cyc - rcyc, vecs[i].lat + 2);
      wait_pops(p0 + 2, "redir");
      check("redir_second_pc", last_pop_pc, vecs[i].exp_pc + 32'd4);
    end

    // Grant withheld: address holds and fetch_pc does not advance.
    do_reset(1, 1'b0, 1'b1);
    repeat (5) step();
    check("nogrant_addr", bus.imem_addr, 32'd0);
    check("nogrant_count", grant_cnt, 32'd0);
    check("nogrant_req", {31'd0, bus.imem_req}, 32'd1);
    bus.imem_gnt = 1'b1;
    wait_grants(2, "nogrant");
    check("nogrant_second_addr", last_grant_addr, 32'd4);

    // Reset in the middle of a stream with two entries buffered.
    do_reset(1, 1'b1, 1'b0);
    wait_grants(2, "midrst");
    bus.imem_gnt = 1'b0;
    repeat (3) step();
    check("midrst_valid_before", {31'd0, bus.instr_valid}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("midrst_valid_drop", {31'd0, bus.instr_valid}, 32'd0);
    check("midrst_req_drop", {31'd0, bus.imem_req}, 32'd0);
    repeat (2) step();
    bus.imem_gnt = 1'b1;
    bus.instr_ready = 1'b1;
    rst = 1'b1;
    clear_counters();
    wait_grants(1, "midrst");
    check("midrst_restart_addr", last_grant_addr, 32'd0);
    wait_pops(2, "midrst");
    check("midrst_second_pc", last_pop_pc, 32'd4);

    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch front end for the 5-stage MIPS pipeline. It owns the fetch PC, issues in-order requests to a variable-latency instruction memory, and buffers returned words in a small in-order queue. It presents one instruction per cycle to the Decode pipeline register. It replaces the bare pc register and pc+4 adder in the Fetch stage. Branch and jump redirects from Decode flush it.

## Interface
Parameters:
- DEPTH, 4: queue entries and maximum outstanding requests; power of two, >= 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  request valid.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req && !imem_gnt.
- imem_gnt  in  1  request accepted when imem_req && imem_gnt.
- imem_rvalid  in  1  one response per accepted request, in order, >= 1 cycle after grant.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- redirect  in  1  taken branch or jump in Decode.
- redirect_pc  in  32  new fetch address, valid with redirect.
- instr_valid  out  1  head entry holds an instruction.
- instr  out  32  head instruction.
- instr_pc  out  32  address of head instruction.
- instr_pc_plus4  out  32  instr_pc + 4.
- instr_ready  in  1  Decode accepts (= ~stallD); pop when instr_valid && instr_ready.

## Operation
- State: fetch_pc, DEPTH entries {pc, data, filled}, pointers alloc_ptr / fill_ptr / head_ptr, each log2(DEPTH)+1 bits with wrap bit, and drop_cnt.
- Credit: used = (alloc_ptr - head_ptr) + drop_cnt.
- imem_req = (used < DEPTH) && !redirect.
- On grant: write entry[alloc_ptr].pc = fetch_pc, clear filled, increment alloc_ptr, fetch_pc += 4. Address arithmetic is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- On imem_rvalid:
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise: write data into entry[fill_ptr], set filled, increment fill_ptr.
- Pop: increment head_ptr. Outputs come combinationally from entry[head_ptr]. instr_valid = (head_ptr != fill_ptr).
- Redirect, which has priority over all other updates that cycle:
  - fetch_pc <= redirect_pc.
  - Set alloc_ptr, fill_ptr and head_ptr equal, which empties the queue.
  - drop_cnt <= drop_cnt + (alloc_ptr - fill_ptr) - (imem_rvalid ? 1 : 0).
  - No grant is possible that cycle because imem_req is low.
  - A simultaneous pop is ignored.
- A second redirect while drop_cnt > 0 accumulates into drop_cnt in the same way.
- redirect_pc[1:0] is ignored and treated as 0.
- Reset (rst low, asynchronous):
  - fetch_pc = RESET_PC.
  - All pointers and drop_cnt = 0; all filled bits = 0.
  - Outputs: imem_req = 0, instr_valid = 0, instr = 0, instr_pc = 0, instr_pc_plus4 = 4.
- The response for a request granted before reset must not reach the queue. The memory is reset by the same rst.

## Timing
- Fetch latency with memory latency L:
  - Grant in cycle t.
  - imem_rvalid in cycle t+L.
  - instr_valid in cycle t+L+1.
  - There is no rvalid-to-output bypass.
- Throughput is one instruction per cycle when DEPTH >= L+2 and instr_ready is held high.
- Full (used == DEPTH): imem_req low, imem_addr holds fetch_pc. The queue resumes the cycle after a pop or a dropped response.
- Empty: instr_valid low. instr and instr_pc show the stale head entry, and Decode must not sample them.
- Redirect in cycle t: the first request to redirect_pc is issued in cycle t+1. The earliest instr_valid for it is t+L+2.
- All state updates happen on the rising edge of clk. The only asynchronous path is rst.

## Structure
- Shared package `fetch_pkg` holds:
  - RESET_PC default.
  - The ifq_entry_t typedef {pc[31:0], data[31:0], filled}.
  - Pointer-width function clog2(DEPTH)+1.
- Sub-module `ifq_storage` holds the entry array:
  - One write port for allocation (pc, clears filled).
  - One write port for fill (data, sets filled).
  - One asynchronous read port at head_ptr.
  - Pointer and credit logic stays in inst_fetch_queue.

## Test plan
- Reset release, memory L=1, gnt tied high, ready high -> imem_addr sequence 0,4,8,...; instr_pc 0 first valid in cycle 3 after release; then one instruction per cycle.
- ready low for 10 cycles, L=1 -> exactly 4 grants; imem_req low with imem_addr = 16; after ready rises, pops in order 0,4,8,12, then fetch resumes at 16.
- L=3, 3 requests outstanding, redirect to 0x100 -> the 3 old responses are discarded (drop_cnt 3→0); the first valid instr_pc is 0x100.
- Redirect in the same cycle as imem_rvalid, with 2 outstanding -> drop_cnt becomes 1; no stale instruction is ever valid.
- imem_gnt held low for 5 cycles -> imem_addr stays stable; fetch_pc advances only on grant.
- rst asserted mid-stream with 2 entries valid -> instr_valid drops immediately; after release, fetch restarts at RESET_PC.
